// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the fetch stage and its consumers (decode reads
// the IF_ID field offsets from here).
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VECTOR = 32'h8000_0004;
  localparam logic [31:0] XADR_VECTOR  = 32'h8000_0008;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  localparam int unsigned IFID_PC4_MSB   = 63;
  localparam int unsigned IFID_PC4_LSB   = 32;
  localparam int unsigned IFID_INSTR_MSB = 31;
  localparam int unsigned IFID_INSTR_LSB = 0;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_JR     = 3'd3,
    SEL_INT    = 3'd4,
    SEL_EXC    = 3'd5
  } npc_sel_e;

endpackage

// File: rtl/pc_select.sv
// Combinational next-PC selection: fixed redirect priority plus the supervisor-bit
// rules (only JR and vectors may change PC[31]; interrupts masked in supervisor mode).
module pc_select
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] ILLOP_VEC = instruction_fetch_pkg::ILLOP_VECTOR,
  parameter logic [31:0] XADR_VEC  = instruction_fetch_pkg::XADR_VECTOR
) (
  input  logic [31:0] pc,
  input  logic        z,
  input  logic        j,
  input  logic        jr,
  input  logic        exception,
  input  logic        interrupt,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic [31:0] seq_pc,
  output logic        redirect,
  output logic        take_int
);

  npc_sel_e sel_s;

  // Priority encode the redirect sources, then mux the target.
  always_comb begin
    seq_pc = {pc[31], pc[30:0] + 31'd4};
    sel_s  = SEL_SEQ;
    if (exception) begin
      sel_s = SEL_EXC;
    end else if (interrupt && !pc[31]) begin
      sel_s = SEL_INT;
    end else if (jr) begin
      sel_s = SEL_JR;
    end else if (j) begin
      sel_s = SEL_JUMP;
    end else if (z) begin
      sel_s = SEL_BRANCH;
    end else begin
      sel_s = SEL_SEQ;
    end

    case (sel_s)
      SEL_EXC:    next_pc = ILLOP_VEC;
      SEL_INT:    next_pc = XADR_VEC;
      SEL_JR:     next_pc = jr_target & 32'hFFFF_FFFC;
      SEL_JUMP:   next_pc = (pc & 32'h8000_0000) | (jump_target & 32'h7FFF_FFFF);
      SEL_BRANCH: next_pc = branch_target;
      SEL_SEQ:    next_pc = seq_pc;
      default:    next_pc = seq_pc;
    endcase

    redirect = (sel_s != SEL_SEQ) && (sel_s != SEL_INT);
    take_int = (sel_s == SEL_INT);
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: owns the PC and the IF_ID register, applies decode redirects,
// inserts one bubble per taken redirect and holds on decode stalls.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = instruction_fetch_pkg::RESET_VECTOR,
  parameter logic [31:0] ILLOP_VECTOR = instruction_fetch_pkg::ILLOP_VECTOR,
  parameter logic [31:0] XADR_VECTOR  = instruction_fetch_pkg::XADR_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_IF_ID_Write,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        exception,
  input  logic        interrupt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [63:0] IF_ID,
  output logic        IF_ID_valid
);

  logic [31:0] pc_r;
  logic [63:0] if_id_r;
  logic        valid_r;
  logic [31:0] next_pc_s;
  logic [31:0] seq_pc_s;
  logic        redirect_s;
  logic        take_int_s;

  pc_select #(
    .ILLOP_VEC (ILLOP_VECTOR),
    .XADR_VEC  (XADR_VECTOR)
  ) u_pc_select (
    .pc            (pc_r),
    .z             (Z),
    .j             (J),
    .jr            (JR),
    .exception     (exception),
    .interrupt     (interrupt),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .next_pc       (next_pc_s),
    .seq_pc        (seq_pc_s),
    .redirect      (redirect_s),
    .take_int      (take_int_s)
  );

  // PC and IF_ID registers; reset beats stall, stall beats every redirect.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_r    <= RESET_VECTOR;
      if_id_r <= 64'h0;
      valid_r <= 1'b0;
    end else if (PC_IF_ID_Write) begin
      pc_r <= next_pc_s;
      if (take_int_s) begin
        // Abandoned fetch address goes in the PC_plus4 slot as the return address.
        if_id_r[IFID_PC4_MSB:IFID_PC4_LSB]     <= pc_r;
        if_id_r[IFID_INSTR_MSB:IFID_INSTR_LSB] <= NOP_WORD;
        valid_r                                <= 1'b0;
      end else if (redirect_s) begin
        if_id_r[IFID_PC4_MSB:IFID_PC4_LSB]     <= seq_pc_s;
        if_id_r[IFID_INSTR_MSB:IFID_INSTR_LSB] <= NOP_WORD;
        valid_r                                <= 1'b0;
      end else begin
        if_id_r[IFID_PC4_MSB:IFID_PC4_LSB]     <= seq_pc_s;
        if_id_r[IFID_INSTR_MSB:IFID_INSTR_LSB] <= imem_rdata;
        valid_r                                <= 1'b1;
      end
    end else begin
      pc_r    <= pc_r;
      if_id_r <= if_id_r;
      valid_r <= valid_r;
    end
  end

  assign imem_addr   = pc_r;
  assign PC          = pc_r;
  assign IF_ID       = if_id_r;
  assign IF_ID_valid = valid_r;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch (IF) stage of the five-stage MIPS pipeline. It owns the program counter and the IF_ID pipeline register that feeds the decode stage. It also applies next-PC selection from the redirect signals resolved in decode (branch, jump, jump-register, exception, interrupt). It inserts a bubble on every taken redirect and holds PC and IF_ID when decode requests a stall.

## Interface
Parameters:
- RESET_VECTOR, 32'h8000_0000, PC value after reset (supervisor mode)
- ILLOP_VECTOR, 32'h8000_0004, target on undefined-instruction exception
- XADR_VECTOR, 32'h8000_0008, target on interrupt

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk, in, 1, sole clock; all state updates on the rising edge
  - rst_n, in, 1, synchronous active-high reset (name kept for codebase consistency; asserted = 1)
- PC_IF_ID_Write, in, 1, 1 = PC and IF_ID may update; 0 = hold (load-use stall from decode)
- Decode redirect inputs:
  - Z, in, 1, taken conditional branch resolved in decode
  - J, in, 1, jump (j/jal) in decode
  - JR, in, 1, jump register (jr/jalr) in decode
  - branch_target, in, 32, PC+4 + (sext(imm)<<2) from decode
  - jump_target, in, 32, {PC_plus4[31:28], index, 2'b00} from decode
  - jr_target, in, 32, rs value from decode
- exception, in, 1, undefined instruction in decode
- interrupt, in, 1, external interrupt request (level)
- imem_addr, out, 32, instruction memory address (= PC)
- imem_rdata, in, 32, instruction word, combinational read of imem_addr
- PC, out, 32, current fetch PC
- IF_ID, out, 64, {PC_plus4[63:32], instruction[31:0]}
- IF_ID_valid, out, 1, 0 = IF_ID holds a bubble

## Operation
- Next-PC priority, evaluated only when PC_IF_ID_Write=1:
  - exception → ILLOP_VECTOR
  - interrupt && PC[31]==0 → XADR_VECTOR
  - JR → {jr_target[31:2], 2'b00}
  - J → {PC[31], jump_target[30:0]}
  - Z → branch_target
  - otherwise → seq_pc
- seq_pc = {PC[31], PC[30:0]+4}. Low 31 bits wrap modulo 2^31. The supervisor bit is never changed by sequential fetch or J; only JR and vectors change it.
- Interrupts are masked while PC[31]==1.
- IF_ID update when PC_IF_ID_Write=1:
  - Normal case: IF_ID <= {seq_pc, imem_rdata}, valid <= 1.
  - Redirect from exception, JR, J or Z: IF_ID <= {seq_pc, 32'h0}, valid <= 0. This flushes the wrong-path fetch.
  - Interrupt: IF_ID <= {PC, 32'h0}, valid <= 0. The PC_plus4 field carries the abandoned fetch address, which decode saves to k0 as the return address.
- Stall (PC_IF_ID_Write=0):
  - PC, IF_ID and IF_ID_valid hold.
  - All redirect inputs are ignored, because decode operands may be stale.
  - A level-held interrupt is taken on the first non-stalled cycle.
- Simultaneous redirects resolve strictly by the priority above. Exactly one target is applied.

## Timing
- Reset values: PC = RESET_VECTOR; IF_ID = 64'h0; IF_ID_valid = 0. Outputs are valid the cycle after rst_n is sampled high-then-low.
- Reset asserted mid-operation overrides stall and all redirects in the same edge.
- imem_addr is combinational from the PC register. Instruction latency is 1 cycle: address PC in cycle n → IF_ID at edge ending cycle n.
- Redirect penalty:
  - Redirect asserted in cycle n → PC = target after edge n.
  - The bubble occupies IF_ID during cycle n+1.
  - The target instruction appears in IF_ID after edge n+1.
  - Cost: one bubble per taken redirect.
- No combinational path from any redirect input to IF_ID or PC outputs; the registers break every path.

## Structure
- Shared pipeline package holds:
  - vector constants RESET_VECTOR, ILLOP_VECTOR, XADR_VECTOR
  - NOP word 32'h0
  - IF_ID field offsets (PC_plus4 = [63:32], instruction = [31:0]), also used by decode
- One sub-module: pc_select (combinational next-PC mux with priority and supervisor-bit rules). PC and IF_ID registers stay in instruction_fetch.

## Test plan
- Reset then free-run with sequential imem:
  - PC = 8000_0000, 8000_0004, 8000_0008 on successive cycles.
  - IF_ID = {8000_0004, mem[0]} after the first edge, with valid=1.
- Z=1, branch_target=8000_0040 at PC=8000_0010:
  - next PC = 8000_0040.
  - IF_ID valid=0 instruction=0 for one cycle.
  - then {8000_0044, mem[0x40]}.
- Stall for 3 cycles with J=1 asserted throughout:
  - PC and IF_ID unchanged, J ignored.
  - After release with J still 1, PC = {PC[31], jump_target[30:0]}.
- Supervisor-bit rules:
  - PC=0000_1000, interrupt=1: PC → 8000_0008, IF_ID = {0000_1000, 0}, valid=0.
  - Repeat at PC=8000_1000: interrupt ignored, PC → 8000_1004.
- exception, interrupt, JR and Z all asserted together: PC → 8000_0004.
- Wrap and JR alignment:
  - PC=7FFF_FFFC, sequential fetch → 0000_0000.
  - JR to 0000_0123 → PC=0000_0120.
  - rst_n pulsed during a stall → PC=8000_0000, valid=0.
